// File: rtl/fifo_ram_ctrl.sv
// FIFO controller in front of a dual-port RAM macro with a one-cycle registered read.
// The head entry is prefetched so deq_data comes straight from the macro's read port.
module fifo_ram_ctrl #(
    parameter int DATA_W = 16000,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data,
    output logic [ADDR_W:0]   count,
    output logic              ram_W0_en,
    output logic [ADDR_W-1:0] ram_W0_addr,
    output logic [DATA_W-1:0] ram_W0_data,
    output logic              ram_R0_en,
    output logic [ADDR_W-1:0] ram_R0_addr,
    input  logic [DATA_W-1:0] ram_R0_data
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              head_valid_q, head_valid_d;

    logic              enq_fire;
    logic              deq_fire;
    logic              fetch;
    logic [ADDR_W:0]   avail;

    always_comb begin
        enq_ready = (cnt_q != DEPTH_CNT) && !flush;
        enq_fire  = enq_valid && enq_ready;
        deq_fire  = head_valid_q && deq_ready;
        // Entries sitting in RAM that have not yet been fetched into the head slot.
        avail     = cnt_q - {{ADDR_W{1'b0}}, head_valid_q};
        fetch     = (avail != '0) && (!head_valid_q || deq_fire) && !flush;

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        head_valid_d = head_valid_q;

        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            cnt_d        = '0;
            head_valid_d = 1'b0;
        end else begin
            wr_ptr_d     = wr_ptr_q + {{(ADDR_W-1){1'b0}}, enq_fire};
            rd_ptr_d     = rd_ptr_q + {{(ADDR_W-1){1'b0}}, fetch};
            cnt_d        = cnt_q + {{ADDR_W{1'b0}}, enq_fire} - {{ADDR_W{1'b0}}, deq_fire};
            head_valid_d = fetch || (head_valid_q && !deq_fire);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            head_valid_q <= head_valid_d;
        end
    end

    assign ram_W0_en   = enq_fire;
    assign ram_W0_addr = wr_ptr_q;
    assign ram_W0_data = enq_data;
    assign ram_R0_en   = fetch;
    assign ram_R0_addr = rd_ptr_q;

    assign deq_valid   = head_valid_q;
    assign deq_data    = ram_R0_data;
    assign count       = cnt_q;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: behavioural RAM macro, scoreboard queue of accepted
// payloads checked on every dequeue, plus directed checks on timing and flags.
module tb_fifo_ram_ctrl;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock;
    logic              reset_n;
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_data;
    logic              deq_valid;
    logic              deq_ready;
    logic [DATA_W-1:0] deq_data;
    logic [ADDR_W:0]   count;
    logic              ram_W0_en;
    logic [ADDR_W-1:0] ram_W0_addr;
    logic [DATA_W-1:0] ram_W0_data;
    logic              ram_R0_en;
    logic [ADDR_W-1:0] ram_R0_addr;
    logic [DATA_W-1:0] ram_R0_data;

    fifo_ram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_ready   (enq_ready),
        .enq_data    (enq_data),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_data    (deq_data),
        .count       (count),
        .ram_W0_en   (ram_W0_en),
        .ram_W0_addr (ram_W0_addr),
        .ram_W0_data (ram_W0_data),
        .ram_R0_en   (ram_R0_en),
        .ram_R0_addr (ram_R0_addr),
        .ram_R0_data (ram_R0_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural macro: registered read, data held when R0_en is low.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;
        if (ram_R0_en) ram_R0_data <= mem[ram_R0_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: independent occupancy model and queue of accepted payloads.
    logic [DATA_W-1:0] sb_q[$];
    int                model_cnt = 0;

    always @(negedge clock) begin
        logic accept;
        logic [DATA_W-1:0] exp_data;
        if (!reset_n) begin
            sb_q.delete();
            model_cnt = 0;
        end else if (flush) begin
            check_eq("flush_enq_ready", 64'(enq_ready), 64'd0);
            check_eq("flush_w0_en", 64'(ram_W0_en), 64'd0);
            sb_q.delete();
            model_cnt = 0;
        end else begin
            accept = enq_valid && (model_cnt != DEPTH);
            check_eq("count", 64'(count), 64'(model_cnt));
            check_eq("enq_ready", 64'(enq_ready), 64'(model_cnt != DEPTH));
            check_eq("w0_en", 64'(ram_W0_en), 64'(accept));
            if (accept) sb_q.push_back(enq_data);
            if (deq_valid && deq_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("deq_underflow", 64'd1, 64'd0);
                end else begin
                    exp_data = sb_q.pop_front();
                    check_eq("deq_data", deq_data, exp_data);
                end
            end
            model_cnt = model_cnt + (accept ? 1 : 0) - ((deq_valid && deq_ready) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        while ((count != 0 || deq_valid) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", 64'(n < budget), 64'd1);
    endtask

    logic [DATA_W-1:0] next_val;

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_data  = '0;
        deq_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Reset then idle.
        @(negedge clock);
        check_eq("rst_enq_ready", 64'(enq_ready), 64'd1);
        check_eq("rst_deq_valid", 64'(deq_valid), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_w0_en", 64'(ram_W0_en), 64'd0);
        check_eq("rst_r0_en", 64'(ram_R0_en), 64'd0);

        // Single enq latency.
        tick();
        enq_valid = 1'b1;
        enq_data  = {8{8'hA5}};
        deq_ready = 1'b1;
        @(negedge clock);
        check_eq("c0_w0_en", 64'(ram_W0_en), 64'd1);
        check_eq("c0_w0_addr", 64'(ram_W0_addr), 64'd0);
        tick();
        enq_valid = 1'b0;
        @(negedge clock);
        check_eq("c1_r0_en", 64'(ram_R0_en), 64'd1);
        check_eq("c1_r0_addr", 64'(ram_R0_addr), 64'd0);
        check_eq("c1_deq_valid", 64'(deq_valid), 64'd0);
        tick();
        @(negedge clock);
        check_eq("c2_deq_valid", 64'(deq_valid), 64'd1);
        check_eq("c2_deq_data", deq_data, {8{8'hA5}});
        tick();
        @(negedge clock);
        check_eq("c3_count", 64'(count), 64'd0);
        check_eq("c3_deq_valid", 64'(deq_valid), 64'd0);

        // Fill to 16 with values 0..15, consumer stalled.
        tick();
        deq_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1'b1;
            enq_data  = 64'(i);
            tick();
        end
        enq_data = 64'h99;
        @(negedge clock);
        check_eq("full_count", 64'(count), 64'd16);
        check_eq("full_enq_ready", 64'(enq_ready), 64'd0);
        check_eq("full_w0_en", 64'(ram_W0_en), 64'd0);
        tick();
        enq_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_eq("hold_deq_valid", 64'(deq_valid), 64'd1);
            check_eq("hold_deq_data", deq_data, 64'd0);
            tick();
        end

        // Alternate deq and enq while full; spans two pointer wraps.
        next_val = 64'd16;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                enq_valid = 1'b0;
                deq_ready = 1'b1;
                @(negedge clock);
                check_eq("alt_count_hi", 64'(count), 64'd16);
            end else begin
                enq_valid = 1'b1;
                enq_data  = next_val;
                next_val  = next_val + 1;
                deq_ready = 1'b0;
                @(negedge clock);
                check_eq("alt_count_lo", 64'(count), 64'd15);
            end
            tick();
        end
        drain(40);

        // Continuous enq and deq every cycle.
        deq_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            enq_valid = 1'b1;
            enq_data  = next_val;
            next_val  = next_val + 1;
            @(negedge clock);
            if (i >= 2) begin
                check_eq("stream_deq_valid", 64'(deq_valid), 64'd1);
                check_eq("stream_count", 64'(count), 64'd2);
            end
            tick();
        end
        drain(10);

        // Flush with 7 entries and a prefetched head.
        deq_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            enq_valid = 1'b1;
            enq_data  = 64'h700 + 64'(i);
            tick();
        end
        enq_valid = 1'b0;
        tick();
        @(negedge clock);
        check_eq("pre_flush_count", 64'(count), 64'd7);
        check_eq("pre_flush_deq_valid", 64'(deq_valid), 64'd1);
        tick();
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 64'hDEAD;
        deq_ready = 1'b1;
        tick();
        flush    = 1'b0;
        enq_data = 64'hBEEF;
        @(negedge clock);
        check_eq("post_flush_count", 64'(count), 64'd0);
        check_eq("post_flush_deq_valid", 64'(deq_valid), 64'd0);
        check_eq("post_flush_w0_addr", 64'(ram_W0_addr), 64'd0);
        tick();
        drain(10);

        // Asynchronous reset mid-transfer.
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1;
            enq_data  = 64'h300 + 64'(i);
            tick();
        end
        enq_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_count", 64'(count), 64'd0);
        check_eq("async_rst_deq_valid", 64'(deq_valid), 64'd0);
        check_eq("async_rst_enq_ready", 64'(enq_ready), 64'd1);
        tick();
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
